// File: rtl/uart_tx_drain_pkg.sv
// uart_tx_drain_pkg: shared FSM state encoding, parity codes and counter-width helper
// for the UART transmit drain.
package uart_tx_drain_pkg;
    typedef enum logic [2:0] {UTX_IDLE, UTX_START, UTX_DATA, UTX_PAR, UTX_STOP} utx_state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    function automatic int get_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter; tick marks the last cycle of each bit,
// restart realigns the period to a frame launch.
module uart_baud_tick
    import uart_tx_drain_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = get_width(CLK_DIV);
    logic [W-1:0] r_cnt;
    assign tick = (r_cnt == '0);
    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= '0;
        else
            r_cnt <= (restart || tick) ? W'(CLK_DIV - 1) : r_cnt - W'(1);
    end
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops words from a first-word-fall-through FIFO and serialises them
// LSB first onto a UART line with optional parity and one or two stop bits.
module uart_tx_drain
    import uart_tx_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy
);
    localparam int BW = get_width(DATA_WIDTH);
    utx_state_t            r_state, w_state;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic [BW-1:0]         r_bit, w_bit;
    logic                  r_par, w_par, r_stop, w_stop, r_tx, w_tx, r_rd, w_rd, r_busy, w_busy;
    logic                  w_tick, w_launch, w_last_stop;
    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (w_launch),
        .tick    (w_tick)
    );
    assign w_last_stop = (STOP_BITS == 1) || r_stop;
    // Launching on the final stop tick keeps back-to-back frames gapless.
    assign w_launch = en && !fifo_empty &&
                      (r_state == UTX_IDLE || (r_state == UTX_STOP && w_tick && w_last_stop));
    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_bit   = r_bit;
        w_par   = r_par;
        w_stop  = r_stop;
        w_tx    = r_tx;
        w_busy  = r_busy;
        w_rd    = 1'b0;
        if (w_launch) begin
            w_state = UTX_START;
            w_shift = fifo_data;
            w_par   = (^fifo_data) ^ (PARITY == PAR_ODD);
            w_bit   = '0;
            w_stop  = 1'b0;
            w_tx    = 1'b0;
            w_busy  = 1'b1;
            w_rd    = 1'b1;
        end else if (w_tick) begin
            case (r_state)
                UTX_START: begin
                    w_state = UTX_DATA;
                    w_tx    = r_shift[0];
                    w_shift = r_shift >> 1;
                end
                UTX_DATA: begin
                    if (r_bit == BW'(DATA_WIDTH - 1)) begin
                        w_state = (PARITY != PAR_NONE) ? UTX_PAR : UTX_STOP;
                        w_tx    = (PARITY != PAR_NONE) ? r_par : 1'b1;
                    end else begin
                        w_bit   = r_bit + BW'(1);
                        w_tx    = r_shift[0];
                        w_shift = r_shift >> 1;
                    end
                end
                UTX_PAR: begin
                    w_state = UTX_STOP;
                    w_tx    = 1'b1;
                end
                UTX_STOP: begin
                    w_state = w_last_stop ? UTX_IDLE : UTX_STOP;
                    w_busy  = !w_last_stop;
                    w_stop  = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= UTX_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_par   <= 1'b0;
            r_stop  <= 1'b0;
            r_tx    <= 1'b1;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_bit   <= w_bit;
            r_par   <= w_par;
            r_stop  <= w_stop;
            r_tx    <= w_tx;
            r_rd    <= w_rd;
            r_busy  <= w_busy;
        end
    end
    assign fifo_rd = r_rd;
    assign tx      = r_tx;
    assign busy    = r_busy;
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: drives three drain variants (no parity/1 stop, even/2 stop, odd/1 stop)
// from queue-based FIFO models and checks every cycle against a frame-arithmetic model.
module tb_uart_tx_drain;
    localparam int CD = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en[3];
    logic       empty[3];
    logic [7:0] data[3];
    logic       rd[3], tx[3], busy[3];
    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] bl[$];
    logic [2:0] cap[3][400];
    logic [2:0] pre[3];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    uart_tx_drain #(.DATA_WIDTH(8), .CLK_DIV(CD), .PARITY(0), .STOP_BITS(1)) d0 (
        .clk(clk), .rst(rst), .en(en[0]), .fifo_empty(empty[0]), .fifo_data(data[0]),
        .fifo_rd(rd[0]), .tx(tx[0]), .busy(busy[0]));
    uart_tx_drain #(.DATA_WIDTH(8), .CLK_DIV(CD), .PARITY(2), .STOP_BITS(2)) d1 (
        .clk(clk), .rst(rst), .en(en[1]), .fifo_empty(empty[1]), .fifo_data(data[1]),
        .fifo_rd(rd[1]), .tx(tx[1]), .busy(busy[1]));
    uart_tx_drain #(.DATA_WIDTH(8), .CLK_DIV(CD), .PARITY(1), .STOP_BITS(1)) d2 (
        .clk(clk), .rst(rst), .en(en[2]), .fifo_empty(empty[2]), .fifo_data(data[2]),
        .fifo_rd(rd[2]), .tx(tx[2]), .busy(busy[2]));

    // FIFO models: a pop pulse removes the head; garbage shows on data while empty.
    always @(negedge clk) begin
        if (rd[0] && q0.size() > 0) void'(q0.pop_front());
        if (rd[1] && q1.size() > 0) void'(q1.pop_front());
        if (rd[2] && q2.size() > 0) void'(q2.pop_front());
        empty[0] = (q0.size() == 0);
        empty[1] = (q1.size() == 0);
        empty[2] = (q2.size() == 0);
        if (empty[0]) data[0] = 8'($urandom); else data[0] = q0[0];
        if (empty[1]) data[1] = 8'($urandom); else data[1] = q1[0];
        if (empty[2]) data[2] = 8'($urandom); else data[2] = q2[0];
    end

    // Expected {tx,busy,rd} at cycle k after the first launch, for words in bl sent back to back.
    function automatic logic [2:0] model(input int inst, input int k);
        int par, sb, fl, f, j;
        logic [7:0] b;
        logic t;
        par = (inst == 1) ? 2 : (inst == 2) ? 1 : 0;
        sb  = (inst == 1) ? 2 : 1;
        fl  = CD * (1 + 8 + ((par != 0) ? 1 : 0) + sb);
        f   = k / fl;
        j   = (k % fl) / CD;
        if (f >= bl.size()) return 3'b100;
        b = bl[f];
        if (j == 0) t = 1'b0;
        else if (j <= 8) t = b[j-1];
        else if (j == 9 && par != 0) t = (^b) ^ (par == 1);
        else t = 1'b1;
        return {t, 1'b1, (k % fl) == 0};
    endfunction

    task automatic run(input int n, input int drop_at);
        @(posedge clk);
        #1;
        foreach (bl[x]) begin
            q0.push_back(bl[x]);
            q1.push_back(bl[x]);
            q2.push_back(bl[x]);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) pre[i] = {tx[i], busy[i], rd[i]};
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) cap[i][k] = {tx[i], busy[i], rd[i]};
            if (k == drop_at) for (int i = 0; i < 3; i++) en[i] = 1'b0;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) en[i] = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back(8'h3C); q1.push_back(8'h3C); q2.push_back(8'h3C);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({tx[i], busy[i], rd[i]} !== 3'b100) begin
                    bad++;
                    $display("FAIL reset d%0d c%0d: tx/busy/rd=%b want 100", i, c, {tx[i], busy[i], rd[i]});
                end
            end
        end
        for (int i = 0; i < 3; i++) en[i] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({tx[i], busy[i], rd[i]} !== 3'b100) begin
                    bad++;
                    $display("FAIL idle_en0 d%0d c%0d: tx/busy/rd=%b want 100", i, c, {tx[i], busy[i], rd[i]});
                end
            end
        end
        total++;
        if (q0.size() + q1.size() + q2.size() !== 3) begin
            bad++;
            $display("FAIL idle_en0 pops: words left=%0d want 3", q0.size() + q1.size() + q2.size());
        end
        @(posedge clk);
        #1;
        q0.delete(); q1.delete(); q2.delete();
        for (int i = 0; i < 3; i++) en[i] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int pops, bz;
        bl = '{8'hA5};
        run(52, -1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (pre[i] !== 3'b100) begin
                bad++;
                $display("FAIL latency d%0d: pre-launch tx/busy/rd=%b want 100", i, pre[i]);
            end
        end
        for (int k = 0; k < 52; k++)
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cap[i][k] !== model(i, k)) begin
                    bad++;
                    $display("FAIL single d%0d k%0d: got %b want %b", i, k, cap[i][k], model(i, k));
                end
            end
        pops = 0;
        bz = 0;
        for (int k = 0; k < 52; k++) begin
            pops += int'(cap[0][k][0]);
            bz += int'(cap[0][k][1]);
        end
        total++;
        if (pops !== 1 || bz !== 40) begin
            bad++;
            $display("FAIL single counts: pops=%0d busy=%0d want 1 and 40", pops, bz);
        end
    endtask

    task automatic test_back_to_back;
        int bz;
        bl = '{8'h00, 8'hFF};
        run(100, -1);
        for (int k = 0; k < 100; k++)
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cap[i][k] !== model(i, k)) begin
                    bad++;
                    $display("FAIL b2b d%0d k%0d: got %b want %b", i, k, cap[i][k], model(i, k));
                end
            end
        bz = 0;
        for (int k = 0; k < 80; k++) bz += int'(cap[0][k][1]);
        total++;
        if (bz !== 80 || cap[0][80][1] !== 1'b0 || cap[0][40] !== 3'b011) begin
            bad++;
            $display("FAIL b2b busy: contiguous=%0d after=%b k40=%b want 80 0 011", bz, cap[0][80][1], cap[0][40]);
        end
        total++;
        if (q0.size() + q1.size() + q2.size() !== 0) begin
            bad++;
            $display("FAIL b2b drained: words left=%0d want 0", q0.size() + q1.size() + q2.size());
        end
    endtask

    task automatic test_parity_stop;
        int st;
        bl = '{8'h07};
        run(52, -1);
        for (int k = 0; k < 52; k++)
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cap[i][k] !== model(i, k)) begin
                    bad++;
                    $display("FAIL parity d%0d k%0d: got %b want %b", i, k, cap[i][k], model(i, k));
                end
            end
        total++;
        if (cap[1][37][2] !== 1'b1 || cap[2][37][2] !== 1'b0) begin
            bad++;
            $display("FAIL parity bit: even=%b odd=%b want 1 0", cap[1][37][2], cap[2][37][2]);
        end
        st = 0;
        for (int k = 40; k < 48; k++) st += int'(cap[1][k][2] && cap[1][k][1]);
        total++;
        if (st !== 8 || cap[1][48][1] !== 1'b0) begin
            bad++;
            $display("FAIL two_stop: stop cycles=%0d busy_after=%b want 8 0", st, cap[1][48][1]);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            bl.delete();
            for (int x = 0; x < int'($urandom_range(1, 4)); x++) bl.push_back(8'($urandom));
            run(bl.size() * 48 + 4, -1);
            for (int k = 0; k < bl.size() * 48 + 4; k++)
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if (cap[i][k] !== model(i, k)) begin
                        bad++;
                        $display("FAIL random r%0d d%0d k%0d: got %b want %b", r, i, k, cap[i][k], model(i, k));
                    end
                end
        end
    endtask

    task automatic test_en_drop;
        bl = '{8'($urandom), 8'($urandom)};
        run(100, 10);
        void'(bl.pop_back());
        for (int k = 0; k < 100; k++)
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cap[i][k] !== model(i, k)) begin
                    bad++;
                    $display("FAIL en_drop d%0d k%0d: got %b want %b", i, k, cap[i][k], model(i, k));
                end
            end
        total++;
        if (q0.size() + q1.size() + q2.size() !== 3) begin
            bad++;
            $display("FAIL en_drop pops: words left=%0d want 3", q0.size() + q1.size() + q2.size());
        end
        @(posedge clk);
        #1;
        q0.delete(); q1.delete(); q2.delete();
        for (int i = 0; i < 3; i++) en[i] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bl = '{8'($urandom)};
        run(14, -1);
        for (int k = 0; k < 14; k++)
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cap[i][k] !== model(i, k)) begin
                    bad++;
                    $display("FAIL reset_mid pre d%0d k%0d: got %b want %b", i, k, cap[i][k], model(i, k));
                end
            end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({tx[i], busy[i], rd[i]} !== 3'b100) begin
                bad++;
                $display("FAIL reset_mid d%0d: tx/busy/rd=%b want 100", i, {tx[i], busy[i], rd[i]});
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({tx[i], busy[i], rd[i]} !== 3'b100) begin
                    bad++;
                    $display("FAIL reset_mid after d%0d c%0d: tx/busy/rd=%b want 100", i, c, {tx[i], busy[i], rd[i]});
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) en[i] = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_parity_stop;
        test_random;
        test_en_drop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Transmit-side consumer for the `fifo` block. It pops bytes from the FIFO read port whenever the FIFO is non-empty and serialises each one onto an 8N1-style UART line, with configurable parity and stop bits. It sits between the CPU-side TX FIFO and the board pin. Its `clk` also drives the FIFO `clk_r`, so no clock crossing happens here.

## Interface
- `DATA_WIDTH`, default 8: bits per frame; must match the FIFO `DATA_WIDTH`.
- `CLK_DIV`, default 868: clocks per bit (100 MHz / 115200); legal range ≥ 4.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset (low = reset), sampled on posedge `clk`.
- `en`  in  1  allow new frames to start; the frame in flight always completes.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_o`; first-word fall-through, valid whenever `!fifo_empty`.
- `fifo_rd`  out  1  FIFO `rd`; registered single-cycle pop pulse.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high from the start-bit edge through the last stop-bit cycle.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PAR (skipped when `PARITY`=0)
  - STOP
- Reset (`rst`=0 at an edge) forces:
  - state IDLE
  - `tx`=1, `fifo_rd`=0, `busy`=0
  - bit counter 0, baud counter 0
- Reset mid-frame aborts the frame: `tx` returns high at that edge and no pop is issued.
- Launch condition, evaluated in IDLE and on the last cycle of the final stop bit: `en && !fifo_empty`.
- At a launch edge:
  - shift register ← `fifo_data`
  - parity accumulator ← XOR of `fifo_data` (inverted for odd)
  - `fifo_rd` ← 1, `tx` ← 0, `busy` ← 1
  - state ← START; baud counter ← `CLK_DIV`-1
- `fifo_rd` clears on the next edge; exactly one pop per frame.
- Baud counter:
  - Decrements each cycle.
  - At 0 the current bit ends: counter reloads `CLK_DIV`-1 and the next bit is driven on `tx` at that edge.
- DATA: LSB first, `DATA_WIDTH` bits; a bit counter of width `GET_WIDTH(DATA_WIDTH)` counts 0..`DATA_WIDTH`-1.
- PAR: one bit, the parity value latched at launch.
- STOP: `STOP_BITS` × `CLK_DIV` cycles of `tx`=1.
- End of final stop bit:
  - Launch condition true → go directly to START; zero idle gap between frames.
  - Otherwise → IDLE, `busy`=0.
- `en` falling mid-frame has no effect until the frame ends.
- `fifo_empty` is ignored outside launch evaluation.
- `fifo_data` changing mid-frame has no effect; data was latched at launch.

## Timing
- Launch latency: `fifo_empty` falling in cycle n while idle gives `tx`=0 and `fifo_rd`=1 visible in cycle n+1.
- Frame length: `CLK_DIV`×(1+`DATA_WIDTH`+(`PARITY`≠0)+`STOP_BITS`) cycles exactly.
- Each bit is held exactly `CLK_DIV` cycles; no jitter.
- Pop/empty ordering: the pop lands at the end of cycle n+1. Updated `fifo_empty` is valid by n+2, well before the next launch evaluation (`CLK_DIV`≥4). This guarantees no double pop and no read of a stale word.
- Throughput: one word per frame. Back-to-back frames are continuous while the FIFO stays non-empty.

## Structure
- Shared header (alongside `functions.vh`):
  - state encodings `UTX_IDLE`..`UTX_STOP`
  - parity codes `PAR_NONE/ODD/EVEN`
- Counter widths use `` `GET_WIDTH ``.
- One sub-module, `uart_baud_tick`:
  - Parameter `CLK_DIV`.
  - Inputs `clk`, `rst`, `restart`.
  - Output `tick`, high on the last cycle of each bit period.
- The top level holds the FSM, shift register, parity logic and `fifo_rd`.

## Test plan
- Reset/idle: hold `rst`=0 for 3 cycles with `fifo_empty`=0 → `tx`=1, `fifo_rd`=0, `busy`=0. After release with `en`=0 → no pop.
- Single byte: `CLK_DIV`=4, `PARITY`=0, FIFO holds 0xA5 → exactly one `fifo_rd` pulse. `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; `busy` high 40 cycles.
- Back-to-back: FIFO holds 0x00, 0xFF → 2 pops, 80 contiguous `busy` cycles, second start bit immediately after the first stop bit. FIFO empty afterwards.
- Parity/stop variants:
  - 0x07, `PARITY`=2 → parity bit 1.
  - 0x07, `PARITY`=1 → parity bit 0.
  - `STOP_BITS`=2 → stop phase of 8 cycles.
- Mid-frame events:
  - Deassert `en` during DATA → frame completes and no further pop.
  - Assert `rst`=0 during DATA → `tx`=1 next cycle, state IDLE, pop count unchanged.
